// File: rtl/proc_run_monitor.sv
// Run monitor between the clock/reset generator and the processor: stretches
// the processor reset, counts run cycles, stamps the first error and enforces a cycle budget.
module proc_run_monitor #(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int MAX_CYCLES      = 100000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err,
  output logic             proc_rst,
  output logic             halt,
  output logic             err_latched,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cycle,
  output logic [CNT_W-1:0] cycle_count,
  output logic             running
);

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'((MAX_CYCLES > 0) ? (MAX_CYCLES - 1) : 0);
  localparam bit                WD_EN     = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    st_hold = 2'd0,
    st_run  = 2'd1,
    st_halt = 2'd2
  } state_t;

  state_t            state_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  // Monitor FSM; every output is a register so err never reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= st_hold;
      hold_cnt_r  <= '0;
      proc_rst    <= 1'b1;
      halt        <= 1'b0;
      err_latched <= 1'b0;
      timeout     <= 1'b0;
      err_cycle   <= '0;
      cycle_count <= '0;
      running     <= 1'b0;
    end else begin
      case (state_r)
        st_hold: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r  <= st_run;
            proc_rst <= 1'b0;
            running  <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
          end
        end
        st_run: begin
          // Anything other than a clean 0 (including X) counts as an error.
          case (err)
            1'b0: begin
              if (WD_EN && (cycle_count == WD_LAST)) begin
                timeout <= 1'b1;
                halt    <= 1'b1;
                running <= 1'b0;
                state_r <= st_halt;
              end else if (cycle_count != CNT_MAX) begin
                cycle_count <= cycle_count + CNT_ONE;
              end else begin
                cycle_count <= cycle_count;
              end
            end
            default: begin
              err_latched <= 1'b1;
              err_cycle   <= cycle_count;
              halt        <= 1'b1;
              running     <= 1'b0;
              state_r     <= st_halt;
            end
          endcase
        end
        st_halt: begin
          state_r <= st_halt;
        end
        default: begin
          // Illegal encoding: restart the reset-hold sequence.
          state_r    <= st_hold;
          hold_cnt_r <= '0;
          proc_rst   <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/proc_run_monitor.md
Name: proc_run_monitor

Overview:
- Sits between the clock/reset generator and the processor top (`proc_beqz_added`).
- Conditions the raw `rst` into a stretched processor reset, `proc_rst`, with synchronous deassertion.
- Counts executed run cycles and consumes the processor's `err` output.
- Latches `err` with a cycle stamp, runs a cycle-budget watchdog, and raises a sticky `halt` for the bench/clock generator to end simulation.

Parameters:
- RST_HOLD_CYCLES, 4: clock edges `proc_rst` stays high after `rst` deasserts; legal range ≥1.
- MAX_CYCLES, 100000: watchdog run-cycle budget; 0 disables the watchdog.
- CNT_W, 32: width of the cycle counter and the stamp.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- err  input  1  processor error flag, from `proc_beqz_added.err`.
- proc_rst  output  1  reset to processor; active-high, asserts asynchronously, deasserts synchronously.
- halt  output  1  sticky end-of-run indicator.
- err_latched  output  1  sticky: `err` was seen while running.
- timeout  output  1  sticky: watchdog budget expired.
- err_cycle  output  CNT_W  value of `cycle_count` when `err` was latched.
- cycle_count  output  CNT_W  run cycles since reset release; 0 in the first RUN cycle.
- running  output  1  high while in RUN state.

Behaviour:
- All outputs are registered. There is one clock, `clk`; reset is asynchronous and active-high via `rst`.
- Reset (`rst`=1, asynchronous, any state, including mid-RUN or HALT):
  - state=HOLD, hold_cnt=0, proc_rst=1.
  - halt=0, err_latched=0, timeout=0, err_cycle=0, cycle_count=0, running=0.
  - Takes effect without waiting for a clock edge.
- States: HOLD, RUN, HALT. Encoding is free.
- HOLD:
  - proc_rst=1; err ignored (processor is in reset, `err` may be X).
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==RST_HOLD_CYCLES-1: go to RUN, proc_rst<=0, running<=1, hold_cnt saturates.
  - Result: exactly RST_HOLD_CYCLES rising edges after `rst` falls, proc_rst drops.
- RUN, evaluated at each rising edge with the current cycle_count=N:
  - If err==1:
    - err_latched<=1, err_cycle<=N, halt<=1, running<=0, go to HALT.
    - cycle_count holds N.
  - Else if MAX_CYCLES!=0 and N==MAX_CYCLES-1:
    - timeout<=1, halt<=1, running<=0, go to HALT.
    - cycle_count holds N.
  - Else cycle_count<=N+1. If N==all-ones, it saturates (holds), with no wrap.
  - Priority: when err and watchdog expiry fall on the same edge, err wins and timeout stays 0.
  - Latency: err high before edge k → err_latched/halt visible after edge k (1 cycle).
- HALT:
  - All outputs frozen; proc_rst stays 0 (processor state preserved for inspection).
  - err ignored, including X.
  - Exit only via `rst`.
- X handling: in RUN, err==X is treated as an error; the bench flags it.
- No combinational path from `err` to any output.

Test Plan:
- Reset release, RST_HOLD_CYCLES=4: `rst` high 3 cycles then low → proc_rst=1 for exactly 4 further rising edges, then 0; running=1; cycle_count=0 in the first RUN cycle, then 1, 2, 3 …
- Error stamp: in RUN, hold err=0 until cycle_count==10, then pulse err for 1 cycle → after that edge err_latched=1, halt=1, err_cycle=10, cycle_count frozen at 10, running=0; later err pulses change nothing.
- Error ignored during HOLD: err=1 throughout HOLD, dropped on the first RUN cycle → err_latched=0, halt=0, cycle_count counts normally.
- Watchdog, MAX_CYCLES=20, err=0: → halt=1 and timeout=1 after the edge with cycle_count=19; cycle_count stays 19; err_latched=0. With MAX_CYCLES=0, run 1000 cycles → no halt, cycle_count=1000.
- Simultaneous, MAX_CYCLES=20: err=1 exactly when cycle_count==19 → err_latched=1, err_cycle=19, timeout=0, halt=1.
- Async reset mid-run and in HALT: assert `rst` between edges at cycle_count=7, and again in HALT → proc_rst=1 and all other outputs 0 immediately (before the next edge); after release, the full HOLD sequence of 4 edges repeats.
